// File: rtl/router_pkg.sv
// Shared definitions for the router packet FIFO: default unit width, clog2 helper,
// and the write-side FSM encoding.
package router_pkg;

  localparam int UWIDTH_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_FILL    = 2'd1,
    W_DISCARD = 2'd2
  } wstate_t;

endpackage

// File: rtl/pkt_fifo_ram.sv
// Packet storage: DEPTH entries of WIDTH units, plus a per-entry length table.
// Synchronous write, asynchronous read; contents are never cleared.
module pkt_fifo_ram
  import router_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_SZ    = clog2(DEPTH),
  parameter int PTR_IN_SZ = clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_SZ-1:0]    waddr,
  input  logic [PTR_IN_SZ-1:0] waddr_in,
  input  logic [UWIDTH-1:0]    wdata,
  input  logic                 len_we,
  input  logic [PTR_IN_SZ-1:0] len_wdata,
  input  logic [PTR_SZ-1:0]    raddr,
  input  logic [PTR_IN_SZ-1:0] raddr_in,
  output logic [UWIDTH-1:0]    rdata,
  output logic [PTR_IN_SZ-1:0] rlen
);

  logic [WIDTH-1:0][UWIDTH-1:0] mem [DEPTH];
  logic [PTR_IN_SZ-1:0]         len [DEPTH];

  always_ff @(posedge clk) begin
    if (we)     mem[waddr][waddr_in] <= wdata;
    if (len_we) len[waddr]           <= len_wdata;
  end

  assign rdata = mem[raddr][raddr_in];
  assign rlen  = len[raddr];

endmodule

// File: rtl/packet_fifo.sv
// Packet FIFO: units stream in over a valid/ready handshake, whole packets commit on
// their last unit, aborted or oversize packets are dropped; reads are fall-through.
module packet_fifo
  import router_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_SZ    = clog2(DEPTH),
  parameter int PTR_IN_SZ = clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [UWIDTH-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_drop,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [UWIDTH-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic [PTR_SZ:0]   pkt_count,
  output logic              full,
  output logic              empty,
  output logic              err_oversize
);

  localparam logic [PTR_SZ:0]    CNT_FULL = (PTR_SZ + 1)'(DEPTH);
  localparam logic [PTR_IN_SZ-1:0] IDX_MAX = PTR_IN_SZ'(WIDTH - 1);
  localparam logic [PTR_IN_SZ-1:0] IDX_ONE = PTR_IN_SZ'(1);
  localparam logic [PTR_SZ-1:0]    PTR_ONE = PTR_SZ'(1);

  wstate_t              state, next_state;
  logic [PTR_SZ-1:0]    wptr, rptr;
  logic [PTR_IN_SZ-1:0] widx, ridx;
  logic [UWIDTH-1:0]    ram_rdata;
  logic [PTR_IN_SZ-1:0] ram_rlen;

  logic wr_fire, store, commit, overflow, rd_fire, release_pkt;

  // Ready depends only on registered state so no input-to-output path exists.
  assign wr_ready = (pkt_count != CNT_FULL) | (state == W_DISCARD);
  assign wr_fire  = wr_valid & wr_ready & ~wr_drop;
  assign store    = wr_fire & (state != W_DISCARD);
  assign commit   = store & wr_last;
  assign overflow = store & ~wr_last & (widx == IDX_MAX);

  assign rd_valid    = (pkt_count != '0);
  assign rd_data     = rd_valid ? ram_rdata : '0;
  assign rd_last     = rd_valid & (ridx == ram_rlen - IDX_ONE);
  assign rd_fire     = rd_valid & rd_ready;
  assign release_pkt = rd_fire & rd_last;

  assign full  = (pkt_count == CNT_FULL);
  assign empty = (pkt_count == '0);

  always_comb begin
    next_state = state;
    if (wr_drop) begin
      next_state = W_IDLE;
    end else if (wr_fire) begin
      case (state)
        W_DISCARD: if (wr_last) next_state = W_IDLE;
        default: begin
          if (wr_last)              next_state = W_IDLE;
          else if (widx == IDX_MAX) next_state = W_DISCARD;
          else                      next_state = W_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= W_IDLE;
      widx         <= '0;
      wptr         <= '0;
      err_oversize <= 1'b0;
    end else begin
      state        <= next_state;
      err_oversize <= overflow;
      if (wr_drop || commit || overflow) widx <= '0;
      else if (store)                    widx <= widx + IDX_ONE;
      if (commit) wptr <= wptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      ridx <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        ridx <= '0;
        rptr <= rptr + PTR_ONE;
      end else begin
        ridx <= ridx + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      case ({commit, release_pkt})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  pkt_fifo_ram #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .UWIDTH(UWIDTH),
    .PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ)
  ) u_ram (
    .clk       (clk),
    .we        (store),
    .waddr     (wptr),
    .waddr_in  (widx),
    .wdata     (wr_data),
    .len_we    (commit),
    .len_wdata (widx + IDX_ONE),
    .raddr     (rptr),
    .raddr_in  (ridx),
    .rdata     (ram_rdata),
    .rlen      (ram_rlen)
  );

endmodule

// File: tb/tb_packet_fifo.sv
// Scoreboard bench for packet_fifo: packets are modelled as whole units lists queued on
// commit, and a monitor pops one unit per read handshake.
module tb_packet_fifo;

  localparam int DEPTH    = 4;
  localparam int WIDTH    = 11;
  localparam int WAIT_MAX = 500;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } unit_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_last = 1'b0;
  logic       wr_drop = 1'b0;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready = 1'b0;
  logic [2:0] pkt_count;
  logic       full, empty, err_oversize;

  int    checks = 0;
  int    failures = 0;
  int    err_seen = 0;
  int    err_exp = 0;
  unit_t exp_q[$];

  packet_fifo dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_drop(wr_drop),
    .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .pkt_count(pkt_count), .full(full), .empty(empty), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every read handshake must match the oldest expected unit.
  initial begin
    unit_t u;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected actual=%0h/%0b required=none", rd_data, rd_last);
          end else begin
            u = exp_q.pop_front();
            chk("rd_unit", {23'd0, rd_data, rd_last}, {23'd0, u.d, u.l});
          end
        end else if (!rd_valid) begin
          chk("rd_idle_zero", {30'd0, rd_data == 8'd0, rd_last}, {30'd0, 1'b1, 1'b0});
        end
        if (err_oversize) err_seen++;
      end
    end
  end

  // drop_at < 0: no abort; otherwise wr_drop is raised on unit index drop_at.
  task automatic send_pkt(input int len, input int drop_at);
    unit_t pk[$];
    int    n;
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      wr_last  = (i == len - 1);
      wr_drop  = (i == drop_at);
      n = 0;
      @(negedge clk);
      while (!wr_ready && !wr_drop && n < WAIT_MAX) begin
        @(negedge clk);
        n++;
      end
      if (n >= WAIT_MAX) begin
        checks++; failures++;
        $display("FAIL wr_ready_timeout actual=0 required=1");
      end
      pk.push_back('{d: wr_data, l: wr_last});
      if (wr_last && drop_at < 0 && len <= WIDTH)
        foreach (pk[k]) exp_q.push_back(pk[k]);
      @(posedge clk); #1;
      if (i == drop_at) break;
    end
    wr_valid = 1'b0; wr_last = 1'b0; wr_drop = 1'b0;
    if (len > WIDTH && (drop_at < 0 || drop_at > WIDTH - 1)) err_exp++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while ((exp_q.size() != 0 || !empty) && n < WAIT_MAX) begin
      @(posedge clk); #1;
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_empty", {31'd0, empty}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, {31'd0, wr_ready}, 1);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 0);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 0);
    chk({tag, "_rd_last"}, {31'd0, rd_last}, 0);
    chk({tag, "_empty"}, {31'd0, empty}, 1);
    chk({tag, "_full"}, {31'd0, full}, 0);
    chk({tag, "_pkt_count"}, {29'd0, pkt_count}, 0);
    chk({tag, "_err"}, {31'd0, err_oversize}, 0);
  endtask

  initial begin
    bit wdone;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 3-unit packet, visible the cycle after its last unit
    send_pkt(3, -1);
    chk("t1_count", {29'd0, pkt_count}, 1);
    chk("t1_rd_valid", {31'd0, rd_valid}, 1);
    drain();

    // fill to DEPTH with one-unit packets
    for (int i = 0; i < DEPTH; i++) send_pkt(1, -1);
    chk("t2_full", {31'd0, full}, 1);
    chk("t2_wr_ready", {31'd0, wr_ready}, 0);
    chk("t2_count", {29'd0, pkt_count}, DEPTH);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("t2_ready_after_release", {31'd0, wr_ready}, 1);
    chk("t2_count_after_release", {29'd0, pkt_count}, DEPTH - 1);
    // simultaneous commit and release
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = 8'hA5;
    exp_q.push_back('{d: 8'hA5, l: 1'b1});
    rd_ready = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
    chk("t2_count_commit_release", {29'd0, pkt_count}, DEPTH - 1);
    send_pkt(1, -1);
    chk("t2_full_again", {31'd0, full}, 1);
    drain();

    // oversize: 13 units, last on the 13th; then a 2-unit packet
    send_pkt(13, -1);
    chk("t3_count", {29'd0, pkt_count}, 0);
    chk("t3_err_once", err_seen, 1);
    send_pkt(2, -1);
    drain();
    // exactly WIDTH units is legal
    send_pkt(WIDTH, -1);
    drain();
    chk("t3_no_err_at_width", err_seen, 1);

    // abort after 5 units
    send_pkt(6, 5);
    chk("t4_no_commit", {29'd0, pkt_count}, 0);
    send_pkt(4, -1);
    drain();

    // reset mid-write and mid-read
    send_pkt(3, -1);
    send_pkt(2, -1);
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_last = 1'b0; wr_data = 8'h3C;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    send_pkt(5, -1);
    drain();

    // randomized traffic with a random consumer
    wdone = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len, drp;
          len = $urandom_range(1, 13);
          drp = ($urandom % 8 == 0) ? int'($urandom_range(0, len - 1)) : -1;
          send_pkt(len, drp);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
        end
        wdone = 1'b1;
      end
      begin
        while (!wdone) begin
          rd_ready = 1'($urandom);
          @(posedge clk); #1;
        end
      end
    join
    drain();
    chk("final_err_count", err_seen, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
